spi_ram_ctrl: RTL
=================

SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 Parameter AUTO_INC, default 0, meaning: 1 = post-increment the stored address after each data write/read.
REQ-002 Parameter RD_LAT, default 1, meaning: RAM read latency in clocks, legal 1..3.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rx_valid  input  1  frame-complete flag from SPI slave, may stay high 2+ cycles per frame.
REQ-006 rx_data  input  10  [9:8] command, [7:0] payload.
REQ-007 ss_n  input  1  SPI slave select, active-low; rising edge ends a frame.
REQ-008 tx_valid  output  1  read data valid towards SPI slave.
REQ-009 tx_data  output  8  read data towards SPI slave.
REQ-010 ram_we  output  1  RAM write strobe, one cycle.
REQ-011 ram_re  output  1  RAM read strobe, one cycle.
REQ-012 ram_addr  output  8  RAM address.
REQ-013 ram_wdata  output  8  RAM write data.
REQ-014 ram_rdata  input  8  RAM read data, valid RD_LAT cycles after ram_re.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 cmd_drop  output  1  one-cycle pulse when a frame arrives outside IDLE.

Function
REQ-017 Frame event = rising edge of rx_valid (rx_valid high, registered copy low); each frame SHALL be acted on exactly once regardless of rx_valid pulse width.
REQ-018 Commands: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
REQ-019 States: IDLE, WRITE, READ, RD_WAIT, TX_HOLD.
REQ-020 IDLE + WR_ADDR: wr_addr <= payload, stay IDLE.
REQ-021 IDLE + RD_ADDR: rd_addr <= payload, stay IDLE.
REQ-022 IDLE + WR_DATA: latch payload, go WRITE; WRITE cycle: ram_we=1, ram_addr=wr_addr, ram_wdata=payload; then IDLE.
REQ-023 IDLE + RD_DATA: go READ; READ cycle: ram_re=1, ram_addr=rd_addr; then RD_WAIT.
REQ-024 RD_WAIT counts RD_LAT cycles, then tx_data <= ram_rdata, tx_valid <= 1, go TX_HOLD.
REQ-025 TX_HOLD: tx_data and tx_valid held stable until ss_n sampled high, then tx_valid <= 0 next cycle, go IDLE.
REQ-026 Write latency: ram_we asserted exactly 2 cycles after the rx_valid rising edge.
REQ-027 Read latency: tx_valid asserted exactly 2+RD_LAT cycles after the rx_valid rising edge.
REQ-028 AUTO_INC=1: wr_addr increments after WRITE, rd_addr after READ; 8'hFF wraps to 8'h00.
REQ-029 RD_DATA with no prior RD_ADDR reads the current rd_addr (reset value 0).
REQ-030 Frame event in any state other than IDLE: frame discarded, registers unchanged, cmd_drop pulses one cycle.
REQ-031 ss_n already high on entering TX_HOLD: tx_valid high exactly one cycle.
REQ-032 ram_we, ram_re, cmd_drop zero in all states except as stated above; ram_addr = 0 when no strobe is asserted.

Reset
REQ-033 rst high asynchronously forces IDLE, wr_addr=0, rd_addr=0, tx_data=0, tx_valid=0, ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0, busy=0, cmd_drop=0, edge register=0.
REQ-034 rst mid-read aborts the transaction; no ram_we or tx_valid is produced for it after release.
REQ-035 rx_valid high at rst release SHALL NOT count as a frame event.

Structure
REQ-036 Package spi_ram_pkg holds the command enum (2 bits), state enum, and localparam ADDR_W=8, DATA_W=8.
REQ-037 One sub-module, rx_edge_det, generates the single-cycle frame event from rx_valid.

Verification
REQ-038 WR_ADDR 0x2A, then WR_DATA 0x5C with rx_valid 2 cycles wide -> exactly one ram_we, addr 0x2A, wdata 0x5C.
REQ-039 RD_ADDR 0x2A, RD_DATA, ram_rdata 0x5C, RD_LAT=2 -> ram_re at addr 0x2A; tx_valid, tx_data 0x5C 4 cycles after edge, held until ss_n rises.
REQ-040 AUTO_INC=1, WR_ADDR 0xFF, two WR_DATA 0x11, 0x22 -> writes at 0xFF then 0x00.
REQ-041 Frame during TX_HOLD -> cmd_drop one cycle, wr_addr/rd_addr unchanged, tx_data unchanged.
REQ-042 rst asserted in RD_WAIT -> all outputs 0 immediately, no tx_valid after release.
REQ-043 RD_DATA immediately after reset -> ram_re with ram_addr 0x00.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI-to-RAM command controller.
// Holds the command and state encodings plus the address/data widths.
package spi_ram_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RD_WAIT,
        ST_TX_HOLD
    } state_e;

endpackage

// File: rtl/spi_ram_ctrl_rx_edge_det.sv
// rx_edge_det: turns a frame-complete level (any width) into one-cycle frame.
// Ports: clk, rst (async, active-high), rx_valid in, frame out.
module rx_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic rx_valid,
    output logic frame
);

    logic rx_q;
    logic armed;

    // armed stays low for the first clock after reset so a rx_valid
    // already high at release is absorbed into rx_q, not seen as a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_q  <= 1'b0;
            armed <= 1'b0;
        end else begin
            rx_q  <= rx_valid;
            armed <= 1'b1;
        end
    end

    assign frame = armed & rx_valid & ~rx_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: decodes SPI frames into RAM address/write/read operations.
// Ports: clk, rst, rx_valid/rx_data/ss_n from SPI slave, tx_valid/tx_data
// back to it, ram_we/ram_re/ram_addr/ram_wdata/ram_rdata, busy, cmd_drop.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int AUTO_INC = 0,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [9:0]        rx_data,
    input  logic              ss_n,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              cmd_drop
);

    localparam logic [1:0] LAT = 2'(RD_LAT);

    state_e            state;
    cmd_e              cmd;
    logic              frame;
    logic [DATA_W-1:0] payload;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        cnt;

    rx_edge_det u_edge (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .frame    (frame)
    );

    assign cmd     = cmd_e'(rx_data[9:8]);
    assign payload = rx_data[7:0];
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wr_addr   <= '0;
            rd_addr   <= '0;
            data_q    <= '0;
            cnt       <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            ram_we    <= 1'b0;
            ram_re    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cmd_drop  <= 1'b0;
        end else begin
            ram_we   <= 1'b0;
            ram_re   <= 1'b0;
            ram_addr <= '0;
            cmd_drop <= frame && (state != ST_IDLE);

            unique case (state)
                ST_IDLE: begin
                    if (frame) begin
                        unique case (cmd)
                            CMD_WR_ADDR: wr_addr <= payload;
                            CMD_RD_ADDR: rd_addr <= payload;
                            CMD_WR_DATA: begin
                                data_q <= payload;
                                cnt    <= '0;
                                state  <= ST_WRITE;
                            end
                            CMD_RD_DATA: begin
                                ram_re   <= 1'b1;
                                ram_addr <= rd_addr;
                                state    <= ST_READ;
                            end
                        endcase
                    end
                end

                // Two cycles: the strobe is issued in the second so that
                // ram_we lands two clocks after the frame edge.
                ST_WRITE: begin
                    if (cnt == 2'd0) begin
                        ram_we    <= 1'b1;
                        ram_addr  <= wr_addr;
                        ram_wdata <= data_q;
                        cnt       <= 2'd1;
                        if (AUTO_INC != 0)
                            wr_addr <= wr_addr + 8'd1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                // ram_re is high during this cycle; the wait count starts
                // at 1 because the strobe cycle itself is latency cycle one.
                ST_READ: begin
                    cnt   <= 2'd1;
                    state <= ST_RD_WAIT;
                    if (AUTO_INC != 0)
                        rd_addr <= rd_addr + 8'd1;
                end

                ST_RD_WAIT: begin
                    if (cnt == LAT) begin
                        tx_data  <= ram_rdata;
                        tx_valid <= 1'b1;
                        state    <= ST_TX_HOLD;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end

                ST_TX_HOLD: begin
                    if (ss_n) begin
                        tx_valid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
